instr_fetch_unit: RTL and testbench

//   Fetch-side initiator for the synchronous instruction memory (1-cycle registered read).

---
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch initiator for a 1-cycle synchronous instruction memory
module instr_fetch_unit #(
   parameter int          MEM_WIDTH  = 64,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'd0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [31:0]           mem_address,
   input  logic [DATA_WIDTH-1:0] mem_instruction,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  halt,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [31:0]           instr_pc,
   output logic                  fetch_fault
);
   typedef enum logic {FETCH, FAULT} state_t;
   state_t                state;
   logic [31:0]           fetch_pc, inflight_pc, last_pc;
   logic                  inflight, rd_ptr, wr_ptr;
   logic [1:0]            count;
   logic [31:0]           pc_q [2];
   logic [DATA_WIDTH-1:0] data_q [2];
   logic                  pop, push, in_range, opportunity, issue;
   logic [2:0]            occ;

   assign pop         = instr_valid & instr_ready;
   assign push        = inflight & ~redirect_valid;
   // slots committed after this edge: buffered minus leaving plus the read still returning
   assign occ         = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
   assign in_range    = fetch_pc < 32'(MEM_WIDTH);
   assign opportunity = (state == FETCH) & ~halt & ~redirect_valid & (occ < 3'd2);
   assign issue       = opportunity & in_range;
   // an out-of-range fetch_pc is never presented to memory; the last issued PC is held instead
   assign mem_address = (state == FETCH && in_range) ? fetch_pc : last_pc;
   assign instr_valid = count != 2'd0;
   assign instr_data  = data_q[rd_ptr];
   assign instr_pc    = pc_q[rd_ptr];

   // PC, fault FSM, in-flight tracking and the 2-entry output FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         last_pc     <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         fetch_fault <= 1'b0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
         pc_q[0]     <= '0;
         pc_q[1]     <= '0;
         data_q[0]   <= '0;
         data_q[1]   <= '0;
      end else if (redirect_valid) begin
         state       <= FETCH;
         fetch_pc    <= redirect_pc;
         fetch_fault <= 1'b0;
         inflight    <= 1'b0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd1;
            last_pc     <= fetch_pc;
         end
         if (opportunity && !in_range) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
         end
         if (push) begin
            pc_q[wr_ptr]   <= inflight_pc;
            data_q[wr_ptr] <= mem_instruction;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch stream, stall, redirect, fault, halt and async reset
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_address;
   logic [31:0] mem_instruction = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        fetch_fault;
   int          checks = 0;
   int          errors = 0;
   int          ovf = 0;
   logic [31:0] exp_pc = '0;
   logic [31:0] hold_addr;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_instruction(mem_instruction),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .instr_pc(instr_pc), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // memory model: word i holds 0x1000+i, one-cycle registered read
   always @(posedge clk) mem_instruction <= 32'h1000 + mem_address;

   // FIFO must never be pushed while full without a simultaneous pop
   always @(posedge clk) if (rst_n && dut.push && dut.count == 2'd2 && !dut.pop) ovf++;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // consume n consecutive instructions, one per cycle, starting at exp_pc
   task automatic expect_stream(input int n);
      for (int i = 0; i < n; i++) begin
         chk("s_valid", 32'(instr_valid), 32'd1);
         chk("s_pc", instr_pc, exp_pc);
         chk("s_data", instr_data, 32'h1000 + exp_pc);
         exp_pc++;
         @(negedge clk);
      end
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc = pc;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rd_valid0", 32'(instr_valid), 32'd0);
      chk("rd_fault0", 32'(fetch_fault), 32'd0);
      @(negedge clk);
      chk("rd_valid1", 32'(instr_valid), 32'd0);
      @(negedge clk);
      exp_pc = pc;
   endtask

   initial begin
      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_data", instr_data, 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      // 1: latency and streaming
      rst_n = 1'b1;
      @(negedge clk);
      chk("lat_e1", 32'(instr_valid), 32'd0);
      @(negedge clk);
      exp_pc = 0;
      expect_stream(8);
      // 2: stall for 5 cycles
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_pc", instr_pc, exp_pc);
         chk("stall_data", instr_data, 32'h1000 + exp_pc);
      end
      chk("stall_addr", mem_address, exp_pc + 32'd2);
      chk("stall_cnt", 32'(dut.count), 32'd2);
      instr_ready = 1'b1;
      expect_stream(6);
      // 3: redirect to 40 with the buffer full
      instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      instr_ready = 1'b1;
      redirect_to(32'd40);
      expect_stream(3);
      // 4: run to the end of memory and fault
      redirect_to(32'd60);
      expect_stream(4);
      chk("f_valid", 32'(instr_valid), 32'd0);
      chk("f_fault", 32'(fetch_fault), 32'd1);
      chk("f_addr", mem_address, 32'd63);
      @(negedge clk);
      chk("f_fault2", 32'(fetch_fault), 32'd1);
      chk("f_addr2", mem_address, 32'd63);
      chk("f_valid2", 32'(instr_valid), 32'd0);
      redirect_to(32'd5);
      expect_stream(3);
      // 5: halt for 4 cycles
      hold_addr = exp_pc + 32'd2;
      halt = 1'b1;
      @(negedge clk);
      chk("h_pc", instr_pc, exp_pc + 32'd1);
      chk("h_valid", 32'(instr_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("h_empty", 32'(instr_valid), 32'd0);
         chk("h_addr", mem_address, hold_addr);
      end
      halt = 1'b0;
      @(negedge clk);
      chk("h_resume0", 32'(instr_valid), 32'd0);
      @(negedge clk);
      exp_pc = hold_addr;
      expect_stream(3);
      // 6: asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(instr_valid), 32'd0);
      chk("ar_fault", 32'(fetch_fault), 32'd0);
      chk("ar_addr", mem_address, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_lat", 32'(instr_valid), 32'd0);
      @(negedge clk);
      exp_pc = 0;
      expect_stream(3);
      chk("no_overflow", 32'(ovf), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
